pipelined_shifter: RTL

//  Parametrised, pipelined barrel shifter for the execute stage: SLL/SRL/SRA plus optional ROL/ROR.
//  Log2(WIDTH) mux levels are split across PIPE_STAGES register stages.
//  A valid/ready handshake on both sides carries a sideband tag, e.g. rd index.

---
 rtl/shifter_pkg.sv | 39 +++
 rtl/pipelined_shifter_level.sv | 34 +++
 rtl/pipelined_shifter.sv | 116 +++++++++++
 3 files changed

// File: rtl/shifter_pkg.sv
// Shared types and stage-partitioning helpers for the pipelined barrel shifter.
// Level-to-stage mapping is computed at elaboration time.
package shifter_pkg;

  typedef enum logic [2:0] {
    OP_SLL = 3'b000,
    OP_SRL = 3'b001,
    OP_SRA = 3'b011,
    OP_ROL = 3'b100,
    OP_ROR = 3'b101
  } shift_op_e;

  // Earlier stages absorb the remainder when levels do not divide evenly.
  function automatic int levels_in_stage(
    int stage, int nlevels, int nstages);
    return nlevels / nstages +
      ((stage < nlevels % nstages) ? 1 : 0);
  endfunction

  function automatic int first_level(
    int stage, int nlevels, int nstages);
    int acc;
    acc = 0;
    for (int s = 0; s < stage; s++)
      acc += levels_in_stage(s, nlevels, nstages);
    return acc;
  endfunction

  function automatic int stage_of(
    int level, int nlevels, int nstages);
    int r;
    r = 0;
    for (int s = 0; s < nstages; s++)
      if (level >= first_level(s, nlevels, nstages))
        r = s;
    return r;
  endfunction

endpackage

// File: rtl/pipelined_shifter_level.sv
// One mux level of the barrel shifter: shifts by DIST when en is set.
// Rotate ops are built only when SHIFTER_ROTATE_EN is defined.
module shift_level
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIST  = 1
) (
  input  logic [WIDTH-1:0] data,
  input  logic             en,
  input  logic [2:0]       op,
  input  logic             fill,
  output logic [WIDTH-1:0] result
);

  always_comb begin
    result = data;
    if (en) begin
      case (op)
        OP_SLL: result = data << DIST;
        OP_SRL: result = data >> DIST;
        OP_SRA: result = {{DIST{fill}}, data[WIDTH-1:DIST]};
`ifdef SHIFTER_ROTATE_EN
        OP_ROL: result = {data[WIDTH-1-DIST:0],
                          data[WIDTH-1:WIDTH-DIST]};
        OP_ROR: result = {data[DIST-1:0],
                          data[WIDTH-1:DIST]};
`endif
        default: result = data;
      endcase
    end
  end

endmodule

// File: rtl/pipelined_shifter.sv
// Pipelined barrel shifter with valid/ready on both sides and a tag sideband.
// Define SHIFTER_ROTATE_EN to build ROL/ROR.
module pipelined_shifter
  import shifter_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int PIPE_STAGES = 2,
  parameter int TAG_W       = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [$clog2(WIDTH)-1:0] in_shamt,
  input  logic [2:0]               in_op,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [TAG_W-1:0]         out_tag
);

  localparam int L  = $clog2(WIDTH);
  localparam int S  = PIPE_STAGES;

  logic [WIDTH-1:0] st_data  [S];
  logic [2:0]       st_op    [S];
  logic [L-1:0]     st_shamt [S];
  logic             st_fill  [S];
  logic [TAG_W-1:0] st_tag   [S];
  logic [S-1:0]     st_valid;

  logic [WIDTH-1:0] src_data  [S];
  logic [2:0]       src_op    [S];
  logic [L-1:0]     src_shamt [S];
  logic             src_fill  [S];
  logic [TAG_W-1:0] src_tag   [S];
  logic [S-1:0]     src_valid;

  logic [WIDTH-1:0] lvl_out   [L];
  logic [WIDTH-1:0] stage_res [S];
  logic [S-1:0]     load;

  for (genvar k = 0; k < S; k++) begin : g_stage
    localparam int LAST = first_level(k + 1, L, S) - 1;
    if (k == 0) begin : g_head
      assign src_data[k]  = in_data;
      assign src_op[k]    = in_op;
      assign src_shamt[k] = in_shamt;
      assign src_fill[k]  = in_data[WIDTH-1];
      assign src_tag[k]   = in_tag;
      assign src_valid[k] = in_valid;
    end else begin : g_body
      assign src_data[k]  = st_data[k-1];
      assign src_op[k]    = st_op[k-1];
      assign src_shamt[k] = st_shamt[k-1];
      assign src_fill[k]  = st_fill[k-1];
      assign src_tag[k]   = st_tag[k-1];
      assign src_valid[k] = st_valid[k-1];
    end
    assign stage_res[k] = lvl_out[LAST];
    // A stage moves when anything from it to the output has room.
    assign load[k] = out_ready | ~(&st_valid[S-1:k]);
  end

  for (genvar l = 0; l < L; l++) begin : g_lvl
    localparam int K = stage_of(l, L, S);
    logic [WIDTH-1:0] lin;
    if (l == first_level(K, L, S)) begin : g_first
      assign lin = src_data[K];
    end else begin : g_chain
      assign lin = lvl_out[l-1];
    end
    shift_level #(
      .WIDTH (WIDTH),
      .DIST  (1 << l)
    ) u_lvl (
      .data   (lin),
      .en     (src_shamt[K][l]),
      .op     (src_op[K]),
      .fill   (src_fill[K]),
      .result (lvl_out[l])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_valid <= '0;
      for (int k = 0; k < S; k++) begin
        st_data[k]  <= '0;
        st_op[k]    <= '0;
        st_shamt[k] <= '0;
        st_fill[k]  <= 1'b0;
        st_tag[k]   <= '0;
      end
    end else begin
      for (int k = 0; k < S; k++) begin
        if (load[k]) begin
          st_valid[k] <= src_valid[k];
          st_data[k]  <= stage_res[k];
          st_op[k]    <= src_op[k];
          st_shamt[k] <= src_shamt[k];
          st_fill[k]  <= src_fill[k];
          st_tag[k]   <= src_tag[k];
        end
      end
    end
  end

  assign in_ready  = load[0];
  assign out_valid = st_valid[S-1];
  assign out_data  = st_data[S-1];
  assign out_tag   = st_tag[S-1];

endmodule
